// File: rtl/z80_arb_pkg.sv
// Shared types for the Z80 work-RAM arbiter.
// Included by z80_busreq_ctrl and z80_ram_arbiter.
package z80_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_Z80,
        GNT_M68
    } grant_t;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/z80_busreq_ctrl.sv
// 68000 -> Z80 bus-request register, BUSREQ drive and ownership flag.
// bus_owned drops one cycle after a release even if BUSACK is still low.
module z80_busreq_ctrl
    import z80_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic busreq_wr,
    input  logic busreq_val,
    input  logic z80_busack_n,
    output logic z80_busreq_n,
    output logic bus_owned
);

    logic busreq_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busreq_reg   <= 1'b0;
            z80_busreq_n <= 1'b1;
            bus_owned    <= 1'b0;
        end else begin
            if (busreq_wr)
                busreq_reg <= busreq_val;
            z80_busreq_n <= ~busreq_reg;
            bus_owned    <= busreq_reg & ~z80_busack_n;
        end
    end

endmodule

// File: rtl/z80_ram_arbiter.sv
// 68000/Z80 arbiter for the shared 8 KB Z80 work RAM.
// Optional: define ARB_TIMEOUT_EN for open-bus timeout of unowned 68000 accesses.
module z80_ram_arbiter
    import z80_arb_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int RAM_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m68_busreq_wr,
    input  logic              m68_busreq_val,
    output logic              m68_busack,
    output logic              z80_busreq_n,
    input  logic              z80_busack_n,
    input  logic              m68_req,
    input  logic              m68_we,
    input  logic [ADDR_W-1:0] m68_addr,
    input  logic [7:0]        m68_wdata,
    output logic [7:0]        m68_rdata,
    output logic              m68_ack,
    input  logic              z80_req,
    input  logic              z80_we,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [7:0]        z80_wdata,
    output logic [7:0]        z80_rdata,
    output logic              z80_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    arb_state_t state;
    grant_t     grant;
    grant_t     last_grant;
    logic       bus_owned;
    logic       acc_we;
    logic       ram_en_q;
    logic       ram_we_q;
    logic [1:0] wait_cnt;
    logic       m68_elig;
    logic       z80_elig;
    logic       pick_m68;

    z80_busreq_ctrl u_busreq (
        .clk          (clk),
        .rst_n        (rst_n),
        .busreq_wr    (m68_busreq_wr),
        .busreq_val   (m68_busreq_val),
        .z80_busack_n (z80_busack_n),
        .z80_busreq_n (z80_busreq_n),
        .bus_owned    (bus_owned)
    );

    assign m68_busack = bus_owned;

    // Gate with reset so a reset edge during ACCESS cannot commit a write.
    assign ram_en = ram_en_q & rst_n;
    assign ram_we = ram_we_q & rst_n;

    always_comb begin
        m68_elig = m68_req & bus_owned;
        z80_elig = z80_req & ~bus_owned;
        pick_m68 = m68_elig & (~z80_elig | (last_grant == GNT_Z80));
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          m68_busy;
    assign m68_busy = (state != IDLE) && (grant == GNT_M68);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= GNT_Z80;
            last_grant <= GNT_Z80;
            acc_we     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 8'h00;
            wait_cnt   <= 2'd0;
            m68_ack    <= 1'b0;
            z80_ack    <= 1'b0;
            m68_rdata  <= 8'h00;
            z80_rdata  <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            m68_ack  <= 1'b0;
            z80_ack  <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m68_elig | z80_elig) begin
                        grant     <= pick_m68 ? GNT_M68 : GNT_Z80;
                        ram_addr  <= pick_m68 ? m68_addr : z80_addr;
                        ram_wdata <= pick_m68 ? m68_wdata : z80_wdata;
                        acc_we    <= pick_m68 ? m68_we : z80_we;
                        ram_we_q  <= pick_m68 ? m68_we : z80_we;
                        ram_en_q  <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (RAM_LAT == 1) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= 2'(RAM_LAT - 2);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0)
                        state <= DONE;
                    else
                        wait_cnt <= wait_cnt - 2'd1;
                end
                DONE: begin
                    if (grant == GNT_M68) begin
                        m68_ack <= 1'b1;
                        if (!acc_we)
                            m68_rdata <= ram_rdata;
                    end else begin
                        z80_ack <= 1'b1;
                        if (!acc_we)
                            z80_rdata <= ram_rdata;
                    end
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef ARB_TIMEOUT_EN
            if (m68_req && !bus_owned && !m68_busy) begin
                if (to_cnt == TW'(TIMEOUT - 1)) begin
                    to_cnt    <= '0;
                    m68_ack   <= 1'b1;
                    m68_rdata <= OPEN_BUS;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else if (!m68_req) begin
                to_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_z80_ram_arbiter.sv
// Directed bench for z80_ram_arbiter with a 1-cycle behavioural RAM.
// Honours ARB_TIMEOUT_EN when the build defines it.
module tb_z80_ram_arbiter;

    localparam int ADDR_W  = 13;
    localparam int RAM_LAT = 1;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m68_busreq_wr;
    logic              m68_busreq_val;
    logic              m68_busack;
    logic              z80_busreq_n;
    logic              z80_busack_n;
    logic              m68_req;
    logic              m68_we;
    logic [ADDR_W-1:0] m68_addr;
    logic [7:0]        m68_wdata;
    logic [7:0]        m68_rdata;
    logic              m68_ack;
    logic              z80_req;
    logic              z80_we;
    logic [ADDR_W-1:0] z80_addr;
    logic [7:0]        z80_wdata;
    logic [7:0]        z80_rdata;
    logic              z80_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    z80_ram_arbiter #(
        .ADDR_W  (ADDR_W),
        .RAM_LAT (RAM_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m68_busreq_wr  (m68_busreq_wr),
        .m68_busreq_val (m68_busreq_val),
        .m68_busack     (m68_busack),
        .z80_busreq_n   (z80_busreq_n),
        .z80_busack_n   (z80_busack_n),
        .m68_req        (m68_req),
        .m68_we         (m68_we),
        .m68_addr       (m68_addr),
        .m68_wdata      (m68_wdata),
        .m68_rdata      (m68_rdata),
        .m68_ack        (m68_ack),
        .z80_req        (z80_req),
        .z80_we         (z80_we),
        .z80_addr       (z80_addr),
        .z80_wdata      (z80_wdata),
        .z80_rdata      (z80_rdata),
        .z80_ack        (z80_ack),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            else
                ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int acks;
        int zacks;
        logic [7:0] got;

        for (int i = 0; i < (1 << ADDR_W); i++)
            mem[i] = 8'h00;
        ram_rdata      = 8'h00;
        rst_n          = 1'b0;
        m68_busreq_wr  = 1'b0;
        m68_busreq_val = 1'b0;
        z80_busack_n   = 1'b1;
        m68_req        = 1'b0;
        m68_we         = 1'b0;
        m68_addr       = '0;
        m68_wdata      = 8'h00;
        z80_req        = 1'b0;
        z80_we         = 1'b0;
        z80_addr       = '0;
        z80_wdata      = 8'h00;

        tick();
        tick();
        check("rst_m68_ack", 32'(m68_ack), 32'd0);
        check("rst_z80_ack", 32'(z80_ack), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_busreq_n", 32'(z80_busreq_n), 32'd1);
        check("rst_busack", 32'(m68_busack), 32'd0);
        check("rst_z80_rdata", 32'(z80_rdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // Z80 read, bus not owned by the 68000
        mem[13'h0100] = 8'hA5;
        z80_req  = 1'b1;
        z80_we   = 1'b0;
        z80_addr = 13'h0100;
        tick();
        check("z80_rd_en", 32'(ram_en), 32'd1);
        check("z80_rd_addr", 32'(ram_addr), 32'h0100);
        tick();
        check("z80_rd_early", 32'(z80_ack), 32'd0);
        tick();
        check("z80_rd_ack", 32'(z80_ack), 32'd1);
        check("z80_rd_data", 32'(z80_rdata), 32'hA5);
        check("z80_rd_m68ack", 32'(m68_ack), 32'd0);
        z80_req = 1'b0;
        tick();
        check("z80_ack_pulse", 32'(z80_ack), 32'd0);
        check("z80_rdata_hold", 32'(z80_rdata), 32'hA5);

        // 68000 write stalls until it owns the bus
        m68_req   = 1'b1;
        m68_we    = 1'b1;
        m68_addr  = 13'h1FFF;
        m68_wdata = 8'h3C;
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m68_ack)
                acks++;
        end
`ifndef ARB_TIMEOUT_EN
        check("m68_stall_noack", 32'(acks), 32'd0);
`endif
        m68_busreq_wr  = 1'b1;
        m68_busreq_val = 1'b1;
        tick();
        m68_busreq_wr = 1'b0;
        tick();
        check("busreq_n_low", 32'(z80_busreq_n), 32'd0);
        check("busack_pre", 32'(m68_busack), 32'd0);
        z80_busack_n = 1'b0;
        tick();
        check("busack_owned", 32'(m68_busack), 32'd1);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (m68_ack) begin
                n = i;
                break;
            end
        end
        check("m68_wr_lat", 32'(n), 32'd3);
        m68_req = 1'b0;
        m68_we  = 1'b0;
        tick();
        check("m68_wr_mem", 32'(mem[13'h1FFF]), 32'h3C);
`ifndef ARB_TIMEOUT_EN
        check("m68_wr_rdata", 32'(m68_rdata), 32'h00);
`endif

        // Owned bus: both request, only the 68000 is served
        mem[13'h0042] = 8'h5A;
        mem[13'h0200] = 8'h77;
        m68_req  = 1'b1;
        m68_addr = 13'h0042;
        z80_req  = 1'b1;
        z80_addr = 13'h0200;
        n = 0;
        zacks = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (z80_ack)
                zacks++;
            if (m68_ack) begin
                n = i;
                break;
            end
        end
        check("both_m68_lat", 32'(n), 32'd3);
        check("both_m68_data", 32'(m68_rdata), 32'h5A);
        m68_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (z80_ack)
                zacks++;
        end
        check("both_z80_starved", 32'(zacks), 32'd0);
        m68_busreq_wr  = 1'b1;
        m68_busreq_val = 1'b0;
        tick();
        m68_busreq_wr = 1'b0;
        tick();
        check("release_busack", 32'(m68_busack), 32'd0);
        z80_busack_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (z80_ack) begin
                n = i;
                break;
            end
        end
        check("regrant_z80_seen", 32'(n != 0), 32'd1);
        check("regrant_z80_data", 32'(z80_rdata), 32'h77);
        z80_req = 1'b0;
        tick();

        // Release during a 68000 read
        m68_busreq_wr  = 1'b1;
        m68_busreq_val = 1'b1;
        tick();
        m68_busreq_wr = 1'b0;
        z80_busack_n  = 1'b0;
        tick();
        check("reacq_busack", 32'(m68_busack), 32'd1);
        mem[13'h0777] = 8'hC3;
        m68_req  = 1'b1;
        m68_addr = 13'h0777;
        tick();
        m68_busreq_wr  = 1'b1;
        m68_busreq_val = 1'b0;
        tick();
        m68_busreq_wr = 1'b0;
        tick();
        check("rel_rd_ack", 32'(m68_ack), 32'd1);
        check("rel_rd_data", 32'(m68_rdata), 32'hC3);
        check("rel_busack", 32'(m68_busack), 32'd0);
        m68_req      = 1'b0;
        z80_busack_n = 1'b1;
        tick();
        m68_req  = 1'b1;
        m68_addr = 13'h0000;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m68_ack)
                acks++;
        end
`ifndef ARB_TIMEOUT_EN
        check("rel_follow_noack", 32'(acks), 32'd0);
`endif
        m68_req = 1'b0;
        tick();
        tick();

        // Reset during ACCESS of a Z80 write
        mem[13'h0055] = 8'h11;
        z80_req   = 1'b1;
        z80_we    = 1'b1;
        z80_addr  = 13'h0055;
        z80_wdata = 8'h99;
        tick();
        check("rstw_ram_we", 32'(ram_we), 32'd1);
        check("rstw_ram_addr", 32'(ram_addr), 32'h0055);
        rst_n = 1'b0;
        tick();
        check("rstw_ram_en", 32'(ram_en), 32'd0);
        check("rstw_ram_addr0", 32'(ram_addr), 32'd0);
        check("rstw_z80_rdata", 32'(z80_rdata), 32'd0);
        check("rstw_busreq_n", 32'(z80_busreq_n), 32'd1);
        rst_n   = 1'b1;
        z80_req = 1'b0;
        z80_we  = 1'b0;
        zacks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (z80_ack)
                zacks++;
        end
        check("rstw_no_ack", 32'(zacks), 32'd0);
        check("rstw_mem", 32'(mem[13'h0055]), 32'h11);

        // Unowned 68000 read: open-bus timeout or indefinite stall
        m68_req  = 1'b1;
        m68_we   = 1'b0;
        m68_addr = 13'h0100;
        n = 0;
        got = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m68_ack) begin
                n = i;
                got = m68_rdata;
                break;
            end
        end
        m68_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        check("to_ack_cycle", 32'(n), 32'(TIMEOUT));
        check("to_open_bus", 32'(got), 32'hFF);
`else
        check("to_no_ack", 32'(n), 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
